// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: shared sizing helpers and types for the BRAM-backed FWFT FIFO.
// Provides depth/capacity/pointer/level width helpers plus the output-buffer op encoding.
// Optional build macro used by the top: FIFO_CTRL_LEVEL_EN (adds level/almost flags).
package bram_fifo_pkg;

  localparam int ADDR_DEFAULT = 6;

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  // BRAM words plus the two output-buffer entries.
  function automatic int cap_of(input int addr);
    return (1 << addr) + 2;
  endfunction

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_w(input int addr);
    return addr + 1;
  endfunction

  // Level must hold 0..2**ADDR+2.
  function automatic int level_w(input int addr);
    return addr + 2;
  endfunction

  localparam int DEPTH = depth_of(ADDR_DEFAULT);
  localparam int CAP   = cap_of(ADDR_DEFAULT);

  typedef enum logic [1:0] {
    BUF_HOLD = 2'b00,
    BUF_POP  = 2'b01,
    BUF_CAP  = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

endpackage

// File: rtl/bram_fifo_outbuf.sv
// bram_fifo_outbuf: 2-entry FIFO that holds words returned by the BRAM read port.
// Ports: capture/cap_data load a word, pop removes the head; buf_cnt, valid, data are registered.
// Latency: a captured word is visible on data the cycle after capture; pop and capture may coincide.
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [DATA-1:0] cap_data,
  input  logic            pop,
  output logic [1:0]      buf_cnt,
  output logic            valid,
  output logic [DATA-1:0] data
);

  logic [DATA-1:0] tail;
  logic [1:0]      cnt_nxt;
  buf_op_e         op;

  assign op = buf_op_e'({capture, pop});

  always_comb begin
    cnt_nxt = buf_cnt;
    case (op)
      BUF_POP: cnt_nxt = buf_cnt - 2'd1;
      BUF_CAP: cnt_nxt = buf_cnt + 2'd1;
      default: cnt_nxt = buf_cnt;
    endcase
  end

  // data is the head entry, tail the second; the controller never lets
  // buffered plus in-flight words exceed two, so capture always has room.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      valid   <= 1'b0;
      data    <= '0;
      tail    <= '0;
    end else begin
      buf_cnt <= cnt_nxt;
      valid   <= (cnt_nxt != 2'd0);
      case (op)
        BUF_POP: data <= tail;
        BUF_CAP: begin
          if (buf_cnt == 2'd0) data <= cap_data;
          else                 tail <= cap_data;
        end
        BUF_BOTH: begin
          if (buf_cnt == 2'd2) begin
            data <= tail;
            tail <= cap_data;
          end else begin
            data <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: turns a 2-port synchronous BRAM into a first-word-fall-through FIFO.
// Ports: in_* write stream, out_* read stream, mem_a_* read port A, mem_b_* write port B.
// Optional macro FIFO_CTRL_LEVEL_EN adds level, almost_full and almost_empty outputs.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA = 8,
  parameter int ADDR = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA-1:0]   out_data,
  output logic              mem_a_we,
  output logic [ADDR-1:0]   mem_a_addr,
  input  logic [DATA-1:0]   mem_a_read,
  output logic              mem_b_we,
  output logic [ADDR-1:0]   mem_b_addr,
  output logic [DATA-1:0]   mem_b_write
`ifdef FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR+1:0]   level,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int PW = ptr_w(ADDR);
  localparam logic [PW-1:0] FULL_CNT = PW'(depth_of(ADDR));

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ram_cnt;
  logic          inflight;
  logic [1:0]    buf_cnt;
  logic [1:0]    occ;
  logic          wr_fire;
  logic          pop;
  logic          issue;

  assign ram_cnt  = wr_ptr - rd_ptr;
  // Ready comes only from pointer state, never from out_ready.
  assign in_ready = (ram_cnt != FULL_CNT);
  assign wr_fire  = in_valid && in_ready && !rst;

  assign mem_b_we    = wr_fire;
  assign mem_b_addr  = wr_ptr[ADDR-1:0];
  assign mem_b_write = in_data;
  assign mem_a_we    = 1'b0;
  assign mem_a_addr  = rd_ptr[ADDR-1:0];

  assign pop = out_valid && out_ready;
  assign occ = buf_cnt + {1'b0, inflight};
  // Issue only while the buffer can absorb the returning word; a same-cycle
  // pop frees the slot the word will land in.
  assign issue = (ram_cnt != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(wr_fire);
      rd_ptr   <= rd_ptr + PW'(issue);
      inflight <= issue;
    end
  end

  bram_fifo_outbuf #(.DATA(DATA)) u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (inflight),
    .cap_data (mem_a_read),
    .pop      (pop),
    .buf_cnt  (buf_cnt),
    .valid    (out_valid),
    .data     (out_data)
  );

`ifdef FIFO_CTRL_LEVEL_EN
  localparam int LW = level_w(ADDR);

  // Total occupancy moves only on an accepted write or a pop.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level + LW'(wr_fire) - LW'(pop);
  end

  assign almost_full  = (level >= LW'(depth_of(ADDR)));
  assign almost_empty = (level <= LW'(1));
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
  localparam int DATA = 8;
  localparam int ADDR = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DATA-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DATA-1:0] out_data;
  logic            mem_a_we;
  logic [ADDR-1:0] mem_a_addr;
  logic [DATA-1:0] mem_a_read;
  logic            mem_b_we;
  logic [ADDR-1:0] mem_b_addr;
  logic [DATA-1:0] mem_b_write;
`ifdef FIFO_CTRL_LEVEL_EN
  logic [ADDR+1:0] level;
  logic            almost_full;
  logic            almost_empty;
`endif

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .mem_a_we    (mem_a_we),
    .mem_a_addr  (mem_a_addr),
    .mem_a_read  (mem_a_read),
    .mem_b_we    (mem_b_we),
    .mem_b_addr  (mem_b_addr),
    .mem_b_write (mem_b_write)
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // BRAM model: registered-address read, old data returned on a same-cycle write.
  logic [DATA-1:0] mem [0:(1<<ADDR)-1];
  always @(posedge clk) begin
    if (mem_b_we) mem[mem_b_addr] <= mem_b_write;
    mem_a_read <= mem[mem_a_addr];
  end

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int pushes = 0;
  int acc;
  logic [DATA-1:0] model_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for the current cycle: FIFO-order model of accepted words.
  task automatic sb();
    logic [DATA-1:0] exp_word;
`ifdef FIFO_CTRL_LEVEL_EN
    chk("level", 32'(level), 32'(model_q.size()));
    chk("almost_full", 32'(almost_full), 32'(model_q.size() >= 64));
    chk("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 1));
`endif
    if (out_valid && out_ready) begin
      chk("pop_nonempty", 32'(model_q.size() > 0), 32'd1);
      if (model_q.size() > 0) begin
        exp_word = model_q.pop_front();
        chk("pop_data", 32'(out_data), 32'(exp_word));
      end
      pops++;
    end
    if (in_valid && in_ready) begin
      chk("no_overflow", 32'(model_q.size() < 66), 32'd1);
      model_q.push_back(in_data);
      pushes++;
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic fin();
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    // Reset state
    half();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_b_we", 32'(mem_b_we), 32'd0);
    chk("rst_mem_a_we", 32'(mem_a_we), 32'd0);
    chk("rst_mem_a_addr", 32'(mem_a_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write: latency to out_valid is 3 cycles
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    half();
    chk("wr_mem_b_we", 32'(mem_b_we), 32'd1);
    chk("wr_mem_b_addr", 32'(mem_b_addr), 32'd0);
    chk("wr_mem_b_write", 32'(mem_b_write), 32'hA5);
    chk("lat_c0_valid", 32'(out_valid), 32'd0);
    fin();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      half();
      chk($sformatf("lat_c%0d_valid", c), 32'(out_valid), 32'(c == 3));
      if (c == 3) chk("lat_c3_data", 32'(out_data), 32'hA5);
      fin();
    end

    // Continuous stream 0..255 with out_ready=1: no bubbles, in_ready steady
    pops = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      half();
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      fin();
    end
    chk("stream_pops_during", 32'(pops), 32'd253);
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_pops_total", 32'(pops), 32'd256);

    // Fill with out_ready=0
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      half();
      if (in_ready) acc++;
      fin();
    end
    chk("fill_accepted", 32'(acc), 32'd66);
    // One-cycle pop while full: ready returns only next cycle
    in_valid = 1'b0; out_ready = 1'b1;
    half();
    chk("full_pulse_in_ready", 32'(in_ready), 32'd0);
    fin();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    half();
    chk("after_pulse_in_ready", 32'(in_ready), 32'd1);
    fin();
    in_valid = 1'b0;
    half();
    chk("refull_in_ready", 32'(in_ready), 32'd0);
    fin();
    pops = 0; out_ready = 1'b1;
    repeat (80) tick();
    chk("drain_pops", 32'(pops), 32'd66);
    chk("drain_model_empty", 32'(model_q.size()), 32'd0);
    half();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    fin();

    // Randomized traffic with varying pressure; wraps pointers many times
    pops = 0; pushes = 0;
    for (int i = 0; i < 5000; i++) begin
      int mode;
      mode = (i / 500) % 3;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      case (mode)
        0: out_ready = ($urandom_range(0, 3) == 0);
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ($urandom_range(0, 1) == 0);
      endcase
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (100) tick();
    chk("rand_model_empty", 32'(model_q.size()), 32'd0);
    chk("rand_push_pop_equal", 32'(pops), 32'(pushes));
    chk("rand_wrapped", 32'(pushes > 256), 32'd1);
    half();
    chk("rand_out_valid", 32'(out_valid), 32'd0);
    fin();

    // Reset with 10 words held and one read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    half();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_mem_a_addr", 32'(mem_a_addr), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
    chk("mid_rst_level", 32'(level), 32'd0);
`endif
    fin();
    // FIFO works normally after the mid-stream reset
    pops = 0;
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("post_rst_pops", 32'(pops), 32'd1);
    chk("post_rst_model_empty", 32'(model_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
